// File: rtl/ring_pattern_monitor.sv
// ring_pattern_monitor: one-hot ring bus checker (position decode, direction, laps, sticky fault).
// Optional RING_MON_BOUNCE_CHECK_EN selects Knight Rider bounce rules instead of ring rules.
module ring_pattern_monitor #(
    parameter int WIDTH = 8,
    parameter int LAP_W = 8
) (
    input  logic                     clk_i,
    input  logic                     sys_rst_i,
    input  logic [WIDTH-1:0]         pattern_i,
    input  logic                     sample_i,
    input  logic                     clear_i,
    output logic [$clog2(WIDTH)-1:0] pos_o,
    output logic                     valid_o,
    output logic                     dir_o,
    output logic [LAP_W-1:0]         lap_o,
    output logic                     error_o,
    output logic [1:0]               err_code_o
);
    localparam int PW = $clog2(WIDTH);
    localparam logic [PW-1:0] TOP = PW'(WIDTH - 1);

    typedef enum logic [1:0] {ACQUIRE, TRACK, FAULT} state_t;

    state_t          state, state_n;
    logic [PW-1:0]   idx, pos_n;
    logic            seen, multi, onehot, up, dn, wrap_up, wrap_dn, bad_bounce, dir_n, lap_inc;
    logic [LAP_W-1:0] lap_n;
    logic [1:0]      code_n;

    always_comb begin
        idx   = '0;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            multi = multi | (seen & pattern_i[i]);
            seen  = seen | pattern_i[i];
            if (pattern_i[i]) idx = PW'(i);
        end
        onehot  = seen & ~multi;
        // with WIDTH=2 both neighbours coincide; up takes priority
        up      = idx == ((pos_o == TOP) ? '0 : pos_o + PW'(1));
        dn      = !up && idx == ((pos_o == '0) ? TOP : pos_o - PW'(1));
        wrap_up = up && pos_o == TOP;
        wrap_dn = dn && pos_o == '0;
`ifdef RING_MON_BOUNCE_CHECK_EN
        bad_bounce = wrap_up || wrap_dn || (dn != dir_o && pos_o != '0 && pos_o != TOP);
        lap_inc    = dn && idx == '0;
`else
        bad_bounce = 1'b0;
        lap_inc    = wrap_up || wrap_dn;
`endif
        state_n = state;
        pos_n   = pos_o;
        dir_n   = dir_o;
        lap_n   = lap_o;
        code_n  = err_code_o;
        if (clear_i) begin
            state_n = ACQUIRE;
            lap_n   = '0;
            code_n  = 2'd0;
        end else if (sample_i) begin
            case (state)
                ACQUIRE: if (onehot) begin
                    state_n = TRACK;
                    pos_n   = idx;
                    dir_n   = 1'b0;
                end
                TRACK: begin
                    if (!onehot) begin
                        state_n = FAULT;
                        code_n  = 2'd1;
                    end else if (idx == pos_o) begin
                        state_n = TRACK;
                    end else if (!(up || dn)) begin
                        state_n = FAULT;
                        code_n  = 2'd2;
                    end else if (bad_bounce) begin
                        state_n = FAULT;
                        code_n  = 2'd3;
                    end else begin
                        pos_n = idx;
                        dir_n = dn;
                        lap_n = (lap_inc && lap_o != '1) ? lap_o + LAP_W'(1) : lap_o;
                    end
                end
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state      <= ACQUIRE;
            pos_o      <= '0;
            dir_o      <= 1'b0;
            lap_o      <= '0;
            err_code_o <= 2'd0;
        end else begin
            state      <= state_n;
            pos_o      <= pos_n;
            dir_o      <= dir_n;
            lap_o      <= lap_n;
            err_code_o <= code_n;
        end
    end

    assign valid_o = state == TRACK;
    assign error_o = state == FAULT;
endmodule

// File: tb/tb_ring_pattern_monitor.sv
// tb_ring_pattern_monitor: directed plus randomized checks against a rule-level model.
module tb_ring_pattern_monitor;
    localparam int W  = 8;
    localparam int LW = 8;

    logic          clk = 1'b0, rst = 1'b1;
    logic [W-1:0]  pattern = '0;
    logic          sample = 1'b0, clear = 1'b0;
    logic [2:0]    pos_o;
    logic          valid_o, dir_o, error_o;
    logic [LW-1:0] lap_o;
    logic [1:0]    err_code_o;

    int tests = 0, fails = 0;
    int mst, mpos, mdir, mlap, mcode;
    int ones, k;
    bit u, d, lapped, bad;

    ring_pattern_monitor #(.WIDTH(W), .LAP_W(LW)) dut (
        .clk_i(clk), .sys_rst_i(rst), .pattern_i(pattern), .sample_i(sample), .clear_i(clear),
        .pos_o(pos_o), .valid_o(valid_o), .dir_o(dir_o), .lap_o(lap_o), .error_o(error_o),
        .err_code_o(err_code_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model: states 0 ACQUIRE, 1 TRACK, 2 FAULT
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mst = 0; mpos = 0; mdir = 0; mlap = 0; mcode = 0;
        end else if (clear) begin
            mst = 0; mlap = 0; mcode = 0;
        end else if (sample) begin
            ones = $countones(pattern);
            k    = (ones == 1) ? $clog2(pattern) : 0;
            if (mst == 0) begin
                if (ones == 1) begin mst = 1; mpos = k; mdir = 0; end
            end else if (mst == 1) begin
                u = k == (mpos + 1) % W;
                d = !u && k == (mpos + W - 1) % W;
`ifdef RING_MON_BOUNCE_CHECK_EN
                bad    = (u && mpos == W - 1) || (d && mpos == 0) ||
                         (int'(d) != mdir && mpos != 0 && mpos != W - 1);
                lapped = d && k == 0;
`else
                bad    = 1'b0;
                lapped = (u && k == 0) || (d && k == W - 1);
`endif
                if (ones != 1) begin mst = 2; mcode = 1; end
                else if (k == mpos) begin end
                else if (!u && !d) begin mst = 2; mcode = 2; end
                else if (bad) begin mst = 2; mcode = 3; end
                else begin
                    if (lapped && mlap < (1 << LW) - 1) mlap++;
                    mpos = k;
                    mdir = int'(d);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("m_pos", int'(pos_o), mpos);
            chk("m_valid", int'(valid_o), int'(mst == 1));
            chk("m_dir", int'(dir_o), mdir);
            chk("m_lap", int'(lap_o), mlap);
            chk("m_error", int'(error_o), int'(mst == 2));
            chk("m_code", int'(err_code_o), mcode);
        end
    end

    task automatic step(input logic [W-1:0] p, input logic s = 1'b1, input logic c = 1'b0);
        pattern = p;
        sample  = s;
        clear   = c;
        @(posedge clk);
        #1;
        sample = 1'b0;
        clear  = 1'b0;
    endtask

    function automatic logic [W-1:0] oh(input int i);
        return W'(1) << i;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pos", int'(pos_o), 0);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_lap", int'(lap_o), 0);
        chk("rst_error", int'(error_o), 0);
        chk("rst_code", int'(err_code_o), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step(8'h00);
        chk("t1_valid0", int'(valid_o), 0);
        step(8'h81);
        chk("t1_valid1", int'(valid_o), 0);
        chk("t1_err", int'(error_o), 0);
        step(8'h01);
        chk("t1_lock_valid", int'(valid_o), 1);
        chk("t1_lock_pos", int'(pos_o), 0);
`ifndef RING_MON_BOUNCE_CHECK_EN
        for (int i = 1; i <= W; i++) begin
            step(oh(i % W));
            chk("t2_pos", int'(pos_o), i % W);
        end
        chk("t2_dir", int'(dir_o), 0);
        chk("t2_lap", int'(lap_o), 1);
        chk("t2_err", int'(error_o), 0);
        step(8'h00, 1'b0, 1'b1);
        step(8'h10);
        step(8'h08);
        chk("t3_pos", int'(pos_o), 3);
        chk("t3_dir", int'(dir_o), 1);
        step(8'h08);
        chk("t3_hold_pos", int'(pos_o), 3);
        chk("t3_hold_dir", int'(dir_o), 1);
        step(8'h00, 1'b0, 1'b1);
        step(8'h04);
        step(8'h24);
        chk("t4_err", int'(error_o), 1);
        chk("t4_code", int'(err_code_o), 1);
        chk("t4_valid", int'(valid_o), 0);
        step(8'h01);
        chk("t4_frozen_pos", int'(pos_o), 2);
        chk("t4_frozen_code", int'(err_code_o), 1);
        step(8'h01, 1'b1, 1'b1);
        chk("t4_clr_err", int'(error_o), 0);
        chk("t4_clr_lap", int'(lap_o), 0);
        chk("t4_clr_valid", int'(valid_o), 0);
        chk("t4_clr_pos", int'(pos_o), 2);
        step(8'h04);
        step(8'h40);
        chk("t5_code", int'(err_code_o), 2);
        step(8'h00, 1'b0, 1'b1);
        step(8'h01);
        for (int l = 0; l < 256; l++)
            for (int i = 1; i <= W; i++) step(oh(i % W));
        chk("t5_sat", int'(lap_o), 255);
`else
        for (int i = 1; i < W; i++) step(oh(i));
        for (int i = W - 2; i >= 0; i--) step(oh(i));
        chk("t6_err", int'(error_o), 0);
        chk("t6_lap", int'(lap_o), 1);
        step(8'h00, 1'b0, 1'b1);
        step(8'h80);
        step(8'h01);
        chk("t6_wrap_code", int'(err_code_o), 3);
        step(8'h00, 1'b0, 1'b1);
        step(8'h01);
        for (int i = 1; i <= 4; i++) step(oh(i));
        step(8'h08);
        chk("t6_rev_code", int'(err_code_o), 3);
`endif
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (n == 1500) begin
                @(posedge clk);
                #3 rst = 1'b1;
                #1;
                chk("arst_pos", int'(pos_o), 0);
                chk("arst_valid", int'(valid_o), 0);
                chk("arst_lap", int'(lap_o), 0);
                chk("arst_error", int'(error_o), 0);
                @(negedge clk);
                rst = 1'b0;
            end
            step(r < 60 ? oh((mpos + 1) % W) :
                 r < 80 ? oh((mpos + W - 1) % W) :
                 r < 85 ? oh(mpos) :
                 r < 92 ? W'($urandom) : oh($urandom_range(0, W - 1)),
                 $urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0);
        end
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ring_pattern_monitor.md
Name: ring_pattern_monitor

Overview:
- Receive-side checker for the 8-bit one-hot ring counter output bus.
- Samples the pattern and decodes the active position to binary.
- Tracks step direction and counts completed laps.
- Flags, with a sticky error, any non-one-hot pattern or illegal step. Sits downstream of the ring/Knight Rider LED driver for self-test and status reporting.

Parameters:
- WIDTH, 8, number of ring stages; must be ≥2.
- LAP_W, 8, width of the lap counter.

Ports:
- clk_i, input, 1, clock, rising-edge.
- sys_rst_i, input, 1, asynchronous active-high reset.
- pattern_i, input, WIDTH, ring pattern under observation.
- sample_i, input, 1, evaluate pattern_i on this rising edge.
- clear_i, input, 1, clears fault and lap count; returns to ACQUIRE.
- pos_o, output, $clog2(WIDTH), decoded index of the set bit.
- valid_o, output, 1, pos_o is locked to a legal pattern.
- dir_o, output, 1, last step direction: 0 = up (index+1), 1 = down (index-1).
- lap_o, output, LAP_W, completed laps, saturating.
- error_o, output, 1, sticky fault flag.
- err_code_o, output, 2, fault cause: 0 none, 1 not one-hot, 2 illegal jump, 3 bounce violation.

Behaviour:
- Clock and reset are fixed: one clock, clk_i; reset sys_rst_i is asynchronous and active-high.
- Reset puts the FSM in ACQUIRE. All outputs are zero: pos_o=0, valid_o=0, dir_o=0, lap_o=0, error_o=0, err_code_o=0.
- All outputs are registered. Response appears one cycle after the sampling edge.
- A pattern is legal when exactly one bit of pattern_i is set. Index idx is the position of that bit.
- Cycles with sample_i=0 leave all state unchanged.
- FSM states: ACQUIRE, TRACK, FAULT.
- ACQUIRE:
  - sample with legal pattern: pos_o=idx, valid_o=1, dir_o=0, go to TRACK.
  - sample with illegal pattern: stay in ACQUIRE, no error raised (the source is allowed to start up with garbage).
- TRACK, on each sample:
  - Not one-hot: go to FAULT, err_code=1.
  - idx==pos_o (hold): no change.
  - idx==(pos_o+1) mod WIDTH: dir_o=0, pos_o=idx.
  - idx==(pos_o-1) mod WIDTH: dir_o=1, pos_o=idx.
  - Any other idx: go to FAULT, err_code=2.
  - WIDTH=2: +1 and -1 steps are the same index. Treat the step as up.
- Lap counting (macro absent):
  - Increment on the wrap WIDTH-1→0 while moving up.
  - Increment on the wrap 0→WIDTH-1 while moving down.
  - Saturates at 2^LAP_W-1; no rollover.
- FAULT:
  - Entering FAULT sets error_o=1, err_code_o=cause and valid_o=0.
  - pos_o, dir_o and lap_o freeze.
  - Further samples are ignored. Only the first cause is recorded.
- clear_i, in any state: next cycle is ACQUIRE with lap_o=0, error_o=0, err_code_o=0, valid_o=0. pos_o and dir_o are preserved.
- clear_i and sample_i in the same cycle: clear wins and the sample is discarded.
- sys_rst_i asserted mid-operation: immediate return to reset values regardless of clock.

Optional Feature:
- Macro: RING_MON_BOUNCE_CHECK_EN.
- Defined (Knight Rider bounce mode):
  - Wrap steps (WIDTH-1↔0) are faults, err_code=3.
  - A direction reversal is legal only when the previous position was 0 or WIDTH-1. A reversal elsewhere is a fault, err_code=3.
  - At pos 0 the only legal step is up; at pos WIDTH-1 the only legal step is down. Holds stay legal.
  - lap_o increments on each arrival at index 0 from index 1.
- Undefined: pure ring rules as above. Reversal is allowed anywhere and err_code 3 never occurs.

Test Plan:
1. Reset, then sample 0x00, 0x81, 0x01 → stays in ACQUIRE on the first two with error_o=0. After 0x01: valid_o=1, pos_o=0.
2. Lock on 0x01, sample 0x02,0x04,…,0x80,0x01 → pos_o steps 1..7 then 0, dir_o=0, lap_o=1, error_o=0.
3. Lock on 0x10, sample 0x08 then 0x08 → pos_o=3, dir_o=1; the repeated 0x08 is a hold with no change.
4. In TRACK at pos 2, sample 0x24 → error_o=1, err_code_o=1, valid_o=0. Then sample 0x01 → no change. Pulse clear_i together with sample_i → ACQUIRE, error_o=0, lap_o=0.
5. In TRACK at pos 2, sample 0x40 → err_code_o=2. With lap_o pre-saturated at 255, a further wrap keeps lap_o=255.
6. With RING_MON_BOUNCE_CHECK_EN:
   - Sequence 0x01→…→0x80→0x40→…→0x01 → no error, lap_o=1.
   - From pos 7, sample 0x01 → err_code_o=3.
   - Reversal at pos 4 → err_code_o=3.
